recover_feed_ctrl: RTL and testbench

RECOVER_FEED_CTRL -- requirements
Module: recover_feed_ctrl

---
 rtl/recover_feed_ctrl.sv | 163 ++++++++++++++++
 tb/tb_recover_feed_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/recover_feed_ctrl.sv
// rtl/recover_feed_ctrl.sv - frame feed sequencer for the recover datapath
// Issues x1/x2 bank reads per beat, aligns bit-reversed indices, and supervises output count.
module recover_feed_ctrl #(
  parameter int NBEAT   = 1025,
  parameter int ADDR_W  = 11,
  parameter int IDX_W   = 11,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              src_stall,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr_col1,
  output logic [ADDR_W-1:0] mem_addr_col2,
  output logic [ADDR_W-1:0] idx_rd_addr,
  input  logic [IDX_W-1:0]  idx_col1,
  input  logic [IDX_W-1:0]  idx_col2,
  output logic              dp_valid,
  output logic              dp_col2_en,
  output logic [IDX_W-1:0]  dp_index_col1,
  output logic [IDX_W-1:0]  dp_index_col2,
  input  logic              dp_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(NBEAT - 1);
  localparam logic [ADDR_W-1:0] NBEAT_A   = ADDR_W'(NBEAT);
  localparam logic [ADDR_W-1:0] OUT_MAX   = '1;
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0] out_cnt_q, out_cnt_d;
  logic [TO_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic              err_q, err_d;
  logic              ready_prev_q, ready_prev_d;
  logic              dv_q, dv_d;
  logic              col2_en_q, col2_en_d;
  logic              issue;
  logic              ready_fall;
  logic [ADDR_W-1:0] beat_m1;
  logic [IDX_W-1:0]  rev1, rev2;

  assign issue      = (state_q == FEED) && !src_stall;
  assign ready_fall = ready_prev_q && !dp_ready;
  assign beat_m1    = beat_cnt_q - ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      out_cnt_q    <= '0;
      drain_cnt_q  <= '0;
      err_q        <= 1'b0;
      ready_prev_q <= 1'b0;
      dv_q         <= 1'b0;
      col2_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      out_cnt_q    <= out_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      err_q        <= err_d;
      ready_prev_q <= ready_prev_d;
      dv_q         <= dv_d;
      col2_en_q    <= col2_en_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    out_cnt_d    = out_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    err_d        = err_q;
    ready_prev_d = dp_ready;
    dv_d         = issue;
    col2_en_d    = issue && (beat_cnt_q >= ADDR_W'(2));

    if ((state_q == FEED || state_q == DRAIN) && dp_ready && out_cnt_q != OUT_MAX)
      out_cnt_d = out_cnt_q + ADDR_W'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FEED;
          beat_cnt_d  = '0;
          out_cnt_d   = '0;
          drain_cnt_d = '0;
          err_d       = 1'b0;
        end
      end
      FEED: begin
        if (issue) begin
          beat_cnt_d = beat_cnt_q + ADDR_W'(1);
          if (beat_cnt_q == LAST_BEAT) state_d = DRAIN;
        end
        // A glitch in the output window is flagged, but the feed keeps going.
        if (ready_fall) err_d = 1'b1;
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + TO_W'(1);
        if (ready_fall) begin
          if (out_cnt_q == NBEAT_A) begin
            state_d = DONE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          if (dp_ready && out_cnt_q > NBEAT_A) err_d = 1'b1;
          if (drain_cnt_q == TO_LAST) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beats 0/1 carry one column each; later beats pair columns 2(b-1) and 2(b-1)+1.
  always_comb begin
    mem_addr_col1 = '0;
    mem_addr_col2 = '0;
    idx_rd_addr   = '0;
    if (mem_rd_en) begin
      idx_rd_addr = beat_cnt_q;
      if (beat_cnt_q < ADDR_W'(2)) begin
        mem_addr_col1 = beat_cnt_q;
      end else begin
        mem_addr_col1 = {beat_m1[ADDR_W-2:0], 1'b0};
        mem_addr_col2 = {beat_m1[ADDR_W-2:0], 1'b1};
      end
    end
  end

  always_comb begin
    rev1 = '0;
    rev2 = '0;
    for (int k = 0; k < IDX_W; k++) begin
      rev1[IDX_W-1-k] = idx_col1[k];
      rev2[IDX_W-1-k] = idx_col2[k];
    end
  end

  assign mem_rd_en     = rst_n && issue;
  assign dp_valid      = rst_n && dv_q;
  assign dp_col2_en    = rst_n && col2_en_q;
  assign dp_index_col1 = dp_valid ? rev1 : '0;
  assign dp_index_col2 = dp_col2_en ? rev2 : '0;
  assign busy          = rst_n && (state_q != IDLE);
  assign done          = rst_n && (state_q == DONE);
  assign err           = rst_n && err_q;

endmodule

// File: tb/tb_recover_feed_ctrl.sv
// tb/tb_recover_feed_ctrl.sv - self-checking bench for recover_feed_ctrl
// Beat schedule and completion outcome are predicted from stall/ready patterns before each frame.
module tb_recover_feed_ctrl;
  localparam int NBEAT = 1025, ADDR_W = 11, IDX_W = 11, TIMEOUT = 4096, MAXC = 6000;

  logic clk = 1'b0;
  logic rst_n, start, src_stall, dp_ready;
  logic mem_rd_en, dp_valid, dp_col2_en, busy, done, err;
  logic [ADDR_W-1:0] mem_addr_col1, mem_addr_col2, idx_rd_addr;
  logic [IDX_W-1:0] idx_col1, idx_col2, dp_index_col1, dp_index_col2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  recover_feed_ctrl #(.NBEAT(NBEAT), .ADDR_W(ADDR_W), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_stall(src_stall),
    .mem_rd_en(mem_rd_en), .mem_addr_col1(mem_addr_col1), .mem_addr_col2(mem_addr_col2),
    .idx_rd_addr(idx_rd_addr), .idx_col1(idx_col1), .idx_col2(idx_col2),
    .dp_valid(dp_valid), .dp_col2_en(dp_col2_en), .dp_index_col1(dp_index_col1),
    .dp_index_col2(dp_index_col2), .dp_ready(dp_ready), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    int         b;
    logic [10:0] i1, i2, c1, c2;
    bit         en;
    logic [10:0] o1, o2;
  } vec_t;
  vec_t vt[6];

  logic [10:0] tab1[2048], tab2[2048];
  bit          stall_c[MAXC], rdy_c[MAXC];
  int          issue_beat[MAXC];
  logic [10:0] got_c1[NBEAT], got_c2[NBEAT], got_o1[NBEAT], got_o2[NBEAT];
  bit          got_en[NBEAT];
  logic [10:0] prev_addr = '0;

  function automatic logic [10:0] bitrev(input logic [10:0] v);
    logic [10:0] r;
    for (int k = 0; k < 11; k++) r[10-k] = v[k];
    return r;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // The bench plays the index table: data follows the address by one cycle.
  task automatic drive_cycle(input bit st, input bit stl, input bit rdy);
    @(posedge clk);
    #1;
    start     = st;
    src_stall = stl;
    dp_ready  = rdy;
    idx_col1  = tab1[prev_addr];
    idx_col2  = tab2[prev_addr];
    @(negedge clk);
  endtask

  task automatic clear_pat();
    for (int c = 0; c < MAXC; c++) begin
      stall_c[c] = 1'b0;
      rdy_c[c]   = 1'b0;
    end
  endtask

  task automatic set_rdy(input int s, input int len);
    for (int c = s; c < s + len; c++) rdy_c[c] = 1'b1;
  endtask

  task automatic fill_tab();
    for (int i = 0; i < 2048; i++) begin
      tab1[i] = 11'($urandom_range(0, 2047));
      tab2[i] = 11'($urandom_range(0, 2047));
    end
    for (int i = 0; i < 6; i++) begin
      tab1[vt[i].b] = vt[i].i1;
      tab2[vt[i].b] = vt[i].i2;
    end
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("%s tbl%0d col1", tag, i), int'(got_c1[vt[i].b]), int'(vt[i].c1));
      chk($sformatf("%s tbl%0d col2", tag, i), int'(got_c2[vt[i].b]), int'(vt[i].c2));
      chk($sformatf("%s tbl%0d col2_en", tag, i), int'(got_en[vt[i].b]), int'(vt[i].en));
      chk($sformatf("%s tbl%0d idx1", tag, i), int'(got_o1[vt[i].b]), int'(vt[i].o1));
      chk($sformatf("%s tbl%0d idx2", tag, i), int'(got_o2[vt[i].b]), int'(vt[i].o2));
    end
  endtask

  // Cycle 0 carries the start pulse; the frame's expectations come from stall_c/rdy_c.
  task automatic run_frame(input string tag, input int ign_start);
    int issued = 0, t_last = 0, end_c = -1, done_c = -1, err_from = MAXC + 10, cnt = 0;
    int ndv = 0, ndone = 0, b, pb, e1, e2;
    for (int c = 0; c < MAXC; c++) issue_beat[c] = -1;
    for (int c = 1; c < MAXC && issued < NBEAT; c++) begin
      if (!stall_c[c]) begin
        issue_beat[c] = issued;
        issued++;
        t_last = c + 1;
      end
    end
    for (int c = 1; c < t_last; c++) begin
      if (rdy_c[c-1] && !rdy_c[c]) err_from = imin(err_from, c + 1);
      if (rdy_c[c]) cnt++;
    end
    for (int c = t_last; end_c < 0 && c < MAXC - 8; c++) begin
      if (rdy_c[c-1] && !rdy_c[c]) begin
        if (cnt == NBEAT) begin
          done_c = c + 1;
          end_c  = c + 1;
        end else begin
          err_from = imin(err_from, c + 1);
          end_c    = c;
        end
      end else begin
        if (rdy_c[c] && cnt > NBEAT) err_from = imin(err_from, c + 1);
        if (c - t_last + 1 == TIMEOUT) begin
          err_from = imin(err_from, c + 1);
          end_c    = c;
        end
      end
      if (rdy_c[c] && cnt < 2047) cnt++;
    end
    if (end_c < 0) end_c = MAXC - 8;

    for (int c = 0; c <= end_c + 4; c++) begin
      drive_cycle(c == 0 || c == ign_start, stall_c[c], rdy_c[c]);
      b  = issue_beat[c];
      pb = (c > 0) ? issue_beat[c-1] : -1;
      chk($sformatf("%s c%0d mem_rd_en", tag, c), int'(mem_rd_en), int'(b >= 0));
      if (b >= 0) begin
        e1 = (b < 2) ? b : 2 * (b - 1);
        e2 = (b < 2) ? 0 : 2 * (b - 1) + 1;
        chk($sformatf("%s c%0d idx_rd_addr", tag, c), int'(idx_rd_addr), b);
        chk($sformatf("%s c%0d col1", tag, c), int'(mem_addr_col1), e1);
        chk($sformatf("%s c%0d col2", tag, c), int'(mem_addr_col2), e2);
        got_c1[b] = mem_addr_col1;
        got_c2[b] = mem_addr_col2;
      end
      chk($sformatf("%s c%0d dp_valid", tag, c), int'(dp_valid), int'(pb >= 0));
      chk($sformatf("%s c%0d dp_col2_en", tag, c), int'(dp_col2_en), int'(pb >= 2));
      chk($sformatf("%s c%0d idx1", tag, c), int'(dp_index_col1),
          (pb >= 0) ? int'(bitrev(tab1[pb])) : 0);
      chk($sformatf("%s c%0d idx2", tag, c), int'(dp_index_col2),
          (pb >= 2) ? int'(bitrev(tab2[pb])) : 0);
      if (pb >= 0) begin
        got_o1[pb] = dp_index_col1;
        got_o2[pb] = dp_index_col2;
        got_en[pb] = dp_col2_en;
      end
      if (dp_valid) ndv++;
      if (done) ndone++;
      chk($sformatf("%s c%0d busy", tag, c), int'(busy), int'(c >= 1 && c <= end_c));
      chk($sformatf("%s c%0d done", tag, c), int'(done), int'(c == done_c));
      if (c >= 1) chk($sformatf("%s c%0d err", tag, c), int'(err), int'(c >= err_from));
      prev_addr = idx_rd_addr;
    end
    chk($sformatf("%s dp_valid count", tag), ndv, NBEAT);
    chk($sformatf("%s done count", tag), ndone, (done_c >= 0) ? 1 : 0);
  endtask

  initial begin
    int nst, ndone;
    bit found;
    vt[0] = '{0,    11'h001, 11'h003, 11'd0,    11'd0,    1'b0, 11'h400, 11'h000};
    vt[1] = '{1,    11'h001, 11'h003, 11'd1,    11'd0,    1'b0, 11'h400, 11'h000};
    vt[2] = '{2,    11'h001, 11'h003, 11'd2,    11'd3,    1'b1, 11'h400, 11'h600};
    vt[3] = '{3,    11'h7FF, 11'h001, 11'd4,    11'd5,    1'b1, 11'h7FF, 11'h400};
    vt[4] = '{100,  11'h0AA, 11'h155, 11'd198,  11'd199,  1'b1, 11'h2A8, 11'h554};
    vt[5] = '{1024, 11'h002, 11'h400, 11'd2046, 11'd2047, 1'b1, 11'h200, 11'h001};

    rst_n = 1'b0; start = 1'b0; src_stall = 1'b0; dp_ready = 1'b0;
    idx_col1 = '0; idx_col2 = '0;
    fill_tab();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset mem_rd_en", int'(mem_rd_en), 0);
    chk("reset dp_valid", int'(dp_valid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset err", int'(err), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset busy", int'(busy), 0);
    chk("post-reset mem_rd_en", int'(mem_rd_en), 0);

    // nominal frame with a start pulse while busy that must be ignored
    clear_pat(); set_rdy(5, NBEAT);
    run_frame("nominal", 50);
    check_table("nominal");

    // 5-cycle stall where beat 100 would issue
    fill_tab(); clear_pat();
    for (int c = 101; c <= 105; c++) stall_c[c] = 1'b1;
    set_rdy(10, NBEAT);
    run_frame("stall", -1);
    check_table("stall");

    // random stalls inside the feed
    fill_tab(); clear_pat();
    for (int i = 0; i < 25; i++) stall_c[$urandom_range(2, 1000)] = 1'b1;
    nst = 0;
    for (int c = 0; c < MAXC; c++) if (stall_c[c]) nst++;
    set_rdy(5 + nst, NBEAT);
    run_frame("rstall", -1);

    clear_pat(); set_rdy(30, 1000);
    run_frame("short", -1);

    clear_pat();
    run_frame("timeout", -1);

    clear_pat(); set_rdy(5, 25); set_rdy(31, 1000);
    run_frame("feedfall", -1);

    // abort mid-frame with reset
    fill_tab();
    drive_cycle(1'b1, 1'b0, 1'b0);
    prev_addr = idx_rd_addr;
    found = 1'b0;
    for (int i = 0; i < 1200 && !found; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b1);
      if (mem_rd_en && idx_rd_addr == 11'd500) found = 1'b1;
      prev_addr = idx_rd_addr;
    end
    chk("reached beat 500", int'(found), 1);
    @(posedge clk); #1; rst_n = 1'b0;
    @(negedge clk);
    chk("in-reset mem_rd_en", int'(mem_rd_en), 0);
    chk("in-reset col1", int'(mem_addr_col1), 0);
    chk("in-reset col2", int'(mem_addr_col2), 0);
    chk("in-reset idx_rd_addr", int'(idx_rd_addr), 0);
    chk("in-reset dp_valid", int'(dp_valid), 0);
    chk("in-reset dp_col2_en", int'(dp_col2_en), 0);
    chk("in-reset idx1", int'(dp_index_col1), 0);
    chk("in-reset idx2", int'(dp_index_col2), 0);
    chk("in-reset busy", int'(busy), 0);
    chk("in-reset done", int'(done), 0);
    chk("in-reset err", int'(err), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("after-reset dp_valid", int'(dp_valid), 0);
    chk("after-reset busy", int'(busy), 0);
    chk("after-reset mem_rd_en", int'(mem_rd_en), 0);
    ndone = 0;
    for (int i = 0; i < 1100; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      if (done || busy || dp_valid) ndone++;
      prev_addr = idx_rd_addr;
    end
    chk("after-reset quiet", ndone, 0);

    fill_tab(); clear_pat();
    for (int i = 0; i < 10; i++) stall_c[$urandom_range(2, 1000)] = 1'b1;
    nst = 0;
    for (int c = 0; c < MAXC; c++) if (stall_c[c]) nst++;
    set_rdy(5 + nst, NBEAT);
    run_frame("clean", 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
